cr_run_ctrl: RTL and testbench
==============================

# cr_run_ctrl

Run controller for the correlator datapath. It consumes the one-cycle command strobes from the command decoder (start, stop, sw_rst) and a run-length register write. It sequences each measurement: clear accumulators, accumulate for a programmed number of sample ticks or until stopped, drain the lag pipeline, then signal completion. It sits between the command decoder and the correlator core, and owns the core's soft reset and accumulate enable.

## Interface
Parameters:
- LEN_W, 32, width of run length and sample counter
- RST_CYC, 4, clk cycles dp_rst is held in CLEAR and SWRST (≥1)
- FLUSH_CYC, 16, clk cycles of pipeline drain in FLUSH (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high hardware reset
- start  in  1  one-cycle start strobe
- stop  in  1  one-cycle stop strobe
- sw_rst  in  1  one-cycle software reset strobe
- len_we  in  1  write strobe for run length
- len_data  in  LEN_W  run length in sample ticks; 0 = free-run until stop
- sample_tick  in  1  one-cycle sample strobe from clock generator
- dp_rst  out  1  synchronous clear to correlator core
- acc_en  out  1  accumulate/shift enable to correlator core
- flush  out  1  high during pipeline drain
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle run-complete pulse
- aborted  out  1  sticky: last run ended by stop
- tick_cnt  out  LEN_W  sample ticks accumulated in current/last run

## Operation
- States: IDLE, CLEAR, RUN, FLUSH, DONE, SWRST. State, counters and registered outputs reset asynchronously on rst: state=IDLE, run_len=0, active_len=0, tick_cnt=0, aborted=0. All outputs read 0 during and after rst.
- run_len is written by len_we in any state. It is copied into active_len on the start that leaves IDLE. Writes during a run do not affect that run.
- Priority per cycle: sw_rst > stop > start.
- IDLE: start → CLEAR. On that edge: tick_cnt=0, aborted=0, active_len=run_len. A stop in IDLE is ignored.
- CLEAR: dp_rst=1 for RST_CYC cycles, then → RUN. A stop in CLEAR → IDLE with aborted=1, no done.
- RUN: acc_en = sample_tick (combinational, same cycle). Each tick increments tick_cnt; tick_cnt saturates at all-ones.
  - If active_len≠0 and a tick brings tick_cnt to active_len → FLUSH.
  - A stop without a completing tick → FLUSH with aborted=1.
  - A stop coinciding with the completing tick: the tick is accumulated and aborted stays 0.
  - A stop coinciding with a non-completing tick: the tick is accumulated, then → FLUSH with aborted=1.
- FLUSH: flush=1, acc_en=0 for FLUSH_CYC cycles, then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- sw_rst in any state (including IDLE) → SWRST. In SWRST: dp_rst=1 for RST_CYC cycles, tick_cnt=0, aborted=0, then → IDLE. run_len is preserved and no done is issued.
- start while busy is ignored, including during DONE and SWRST.
- busy = (state≠IDLE). dp_rst is high only in CLEAR and SWRST; flush only in FLUSH; done only in DONE.

## Timing
- start sampled at edge 0: CLEAR occupies cycles 1..RST_CYC, and RUN starts at cycle RST_CYC+1. A tick arriving in CLEAR is not counted.
- The completing tick in cycle t puts FLUSH at cycles t+1..t+FLUSH_CYC, DONE at t+FLUSH_CYC+1, and IDLE at t+FLUSH_CYC+2.
- A stop in RUN at cycle t puts FLUSH at t+1.
- sw_rst at cycle t puts SWRST at t+1..t+RST_CYC and IDLE at t+RST_CYC+1.
- tick_cnt updates on the edge after the tick and holds its value in IDLE until the next start or sw_rst.
- rst asserted mid-run forces IDLE immediately. No done, no dp_rst pulse.

## Test plan
- Normal run, defaults, run_len=5, one tick every 3 cycles, start at cycle 0 → dp_rst cycles 1–4, acc_en on 5 ticks, tick_cnt=5, flush 16 cycles, single done, aborted=0, busy falls after done.
- Free-run, run_len=0, stop after 7 ticks → tick_cnt=7, FLUSH next cycle, done pulses, aborted=1. A following start clears aborted and tick_cnt.
- Collisions: stop on the 5th (completing) tick → acc_en=1 that cycle, tick_cnt=5, aborted=0. Start+stop+sw_rst together in RUN → SWRST, dp_rst 4 cycles, no done, tick_cnt=0.
- len_we=9 mid-run with active_len=3 → run ends at 3. The next run ends at 9. start during FLUSH is ignored.
- Stop during CLEAR → IDLE right after, aborted=1, no done. sw_rst in FLUSH → no done.
- Async rst asserted mid-RUN → all outputs 0 immediately, run_len=0. After release, start gives a free-run.

Source files
------------

// File: rtl/cr_run_ctrl_if.sv
// Command/status bundle between the command decoder, the run controller and the correlator core.
interface cr_run_ctrl_if #(
  parameter int LEN_W = 32
);
  logic             start;
  logic             stop;
  logic             sw_rst;
  logic             len_we;
  logic [LEN_W-1:0] len_data;
  logic             sample_tick;
  logic             dp_rst;
  logic             acc_en;
  logic             flush;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] tick_cnt;

  modport master (
    output start, stop, sw_rst, len_we, len_data, sample_tick,
    input  dp_rst, acc_en, flush, busy, done, aborted, tick_cnt
  );

  modport slave (
    input  start, stop, sw_rst, len_we, len_data, sample_tick,
    output dp_rst, acc_en, flush, busy, done, aborted, tick_cnt
  );
endinterface

// File: rtl/cr_run_ctrl.sv
// Run controller: clears the correlator, accumulates for a programmed number of sample
// ticks or until stopped, drains the lag pipeline and then reports completion.
module cr_run_ctrl #(
  parameter int LEN_W     = 32,
  parameter int RST_CYC   = 4,
  parameter int FLUSH_CYC = 16
) (
  input logic         clk,
  input logic         rst,
  cr_run_ctrl_if.slave bus
);
  localparam int CNT_MAX = (RST_CYC > FLUSH_CYC) ? RST_CYC : FLUSH_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DONE,
    S_SWRST
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic [LEN_W-1:0] run_len;
  logic [LEN_W-1:0] active_len;
  logic [LEN_W-1:0] tick_cnt;
  logic [LEN_W-1:0] tick_inc;
  logic             dp_rst_q;
  logic             flush_q;
  logic             done_q;
  logic             busy_q;
  logic             aborted_q;
  logic             cnt_zero;
  logic             tick_in_run;
  logic             run_complete;

  // phase_cnt counts down the remaining cycles of CLEAR, FLUSH and SWRST
  assign cnt_zero     = (phase_cnt == '0);
  assign tick_in_run  = (state == S_RUN) && bus.sample_tick;
  assign tick_inc     = (&tick_cnt) ? tick_cnt : tick_cnt + LEN_W'(1);
  assign run_complete = tick_in_run && (active_len != '0) && (tick_inc == active_len);

  always_comb begin
    state_nxt = state;
    if (bus.sw_rst) begin
      state_nxt = S_SWRST;
    end else begin
      unique case (state)
        S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
        S_CLEAR: begin
          if (bus.stop)        state_nxt = S_IDLE;
          else if (cnt_zero)   state_nxt = S_RUN;
        end
        S_RUN:   if (run_complete || bus.stop) state_nxt = S_FLUSH;
        S_FLUSH: if (cnt_zero) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        S_SWRST: if (cnt_zero) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Status strobes are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      run_len    <= '0;
      active_len <= '0;
      tick_cnt   <= '0;
      aborted_q  <= 1'b0;
      dp_rst_q   <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (bus.len_we) run_len <= bus.len_data;

      state    <= state_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      dp_rst_q <= (state_nxt == S_CLEAR) || (state_nxt == S_SWRST);
      flush_q  <= (state_nxt == S_FLUSH);
      done_q   <= (state_nxt == S_DONE);

      if (bus.sw_rst)              phase_cnt <= RST_LOAD;
      else if (state_nxt != state) phase_cnt <= (state_nxt == S_FLUSH) ? FLUSH_LOAD : RST_LOAD;
      else if (!cnt_zero)          phase_cnt <= phase_cnt - CNT_W'(1);

      // A stop alongside the completing tick is a normal finish, not an abort
      if (bus.sw_rst) begin
        tick_cnt  <= '0;
        aborted_q <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.start) begin
              tick_cnt   <= '0;
              aborted_q  <= 1'b0;
              active_len <= run_len;
            end
          end
          S_CLEAR: if (bus.stop) aborted_q <= 1'b1;
          S_RUN: begin
            if (tick_in_run) tick_cnt <= tick_inc;
            if (bus.stop && !run_complete) aborted_q <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.dp_rst   = dp_rst_q;
  assign bus.acc_en   = tick_in_run;
  assign bus.flush    = flush_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.tick_cnt = tick_cnt;
endmodule

// File: tb/tb_cr_run_ctrl.sv
// Randomised bench for cr_run_ctrl: a run-timeline reference model predicts each busy episode,
// and a monitor summarises what the DUT did per episode and compares against the queue.
module tb_cr_run_ctrl;
  localparam int LEN_W = 32;
  localparam int R     = 4;
  localparam int F     = 16;
  localparam int BIG   = 1 << 30;
  localparam int M_NONE       = 0;
  localparam int M_TRIPLE     = 1;
  localparam int M_LENWE      = 2;
  localparam int M_START_LATE = 3;
  localparam int M_SW_FLUSH   = 4;

  typedef struct {
    int idle_cyc;
    int dp_n;
    int fl_n;
    int done_n;
    int acc_n;
    int tick;
    int ab;
  } ep_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   m_run_len = 0;
  int   last_tick = 0;
  int   last_ab = 0;
  bit   in_ep = 1'b0;
  ep_t  obs;
  ep_t  exp_e;
  ep_t  sb_q[$];

  cr_run_ctrl_if #(.LEN_W(LEN_W)) bus();

  cr_run_ctrl #(.LEN_W(LEN_W), .RST_CYC(R), .FLUSH_CYC(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic zeroInputs();
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.sw_rst      = 1'b0;
    bus.len_we      = 1'b0;
    bus.len_data    = '0;
    bus.sample_tick = 1'b0;
  endtask

  // Monitor: gathers one summary per busy episode and checks held status while idle
  always @(negedge clk) begin
    if (bus.busy) begin
      if (!in_ep) begin
        in_ep = 1'b1;
        obs   = '{default: 0};
      end
      obs.dp_n   += int'(bus.dp_rst);
      obs.fl_n   += int'(bus.flush);
      obs.done_n += int'(bus.done);
      obs.acc_n  += int'(bus.acc_en);
    end else begin
      if (in_ep) begin
        in_ep = 1'b0;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL episode_unexpected: actual=ended required=no episode pending (cycle %0d)", cyc);
        end else begin
          exp_e = sb_q.pop_front();
          checkOutput("episode_end_cycle", cyc, exp_e.idle_cyc);
          checkOutput("dp_rst_cycles", obs.dp_n, exp_e.dp_n);
          checkOutput("flush_cycles", obs.fl_n, exp_e.fl_n);
          checkOutput("done_pulses", obs.done_n, exp_e.done_n);
          checkOutput("acc_en_cycles", obs.acc_n, exp_e.acc_n);
          checkOutput("tick_cnt_end", bus.tick_cnt, exp_e.tick);
          checkOutput("aborted_end", bus.aborted, exp_e.ab);
          last_tick = exp_e.tick;
          last_ab   = exp_e.ab;
        end
      end
      checkOutput("idle_strobes", {bus.dp_rst, bus.flush, bus.done, bus.acc_en}, 0);
      checkOutput("idle_tick_cnt", bus.tick_cnt, last_tick);
      checkOutput("idle_aborted", bus.aborted, last_ab);
    end
  end

  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      zeroInputs();
      bus.sample_tick = 1'($urandom_range(1));
      bus.stop        = ($urandom_range(3) == 0);
      bus.len_data    = LEN_W'($urandom);
    end
    @(posedge clk); #1;
    zeroInputs();
  endtask

  task automatic writeLen(input int v);
    bus.len_we   = 1'b1;
    bus.len_data = LEN_W'(v);
    m_run_len    = v;
    @(posedge clk); #1;
    zeroInputs();
  endtask

  // Reference model: a timeline of phase windows relative to the start period k=0
  task automatic applyStimulus(input int tick_pct, input int stop_k, input int stop_tick_n,
                               input int sw_k, input int hw_k, input int mode);
    ep_t e;
    int  base, act_len, cnt, ab;
    int  dp_a, dp_b, run_a, run_b, fl_a, fl_b, done_at, idle_at;
    bit  tk, st, sw, sa, lw, in_run, swr, fin;
    e = '{default: 0};
    base = cyc; act_len = m_run_len; cnt = 0; ab = 0; swr = 1'b0;
    dp_a = 1; dp_b = R; run_a = R + 1; run_b = BIG;
    fl_a = BIG; fl_b = -1; done_at = -1; idle_at = BIG;
    for (int k = 0; k < 4000; k++) begin
      if (k == hw_k) begin
        rst = 1'b1; idle_at = k; m_run_len = 0; cnt = 0; ab = 0;
      end
      if (k == idle_at) begin
        zeroInputs();
        e.idle_cyc = base + k;
        e.tick     = cnt;
        e.ab       = ab;
        sb_q.push_back(e);
        return;
      end
      in_run = (k >= run_a) && (k <= run_b);
      tk = (tick_pct < 0) ? (k % 3 == 0) : (int'($urandom_range(99)) < tick_pct);
      st = (k == stop_k) || (stop_tick_n != 0 && in_run && tk && cnt + 1 == stop_tick_n);
      sw = (k == sw_k) || (mode == M_SW_FLUSH && k == fl_a + 2);
      sa = (k == 0) || (mode == M_START_LATE && (k == fl_a + 1 || k == done_at));
      lw = (mode == M_LENWE) && (k == run_a + 1);
      if (mode == M_TRIPLE && k == run_a + 3) begin
        sw = 1'b1; st = 1'b1; sa = 1'b1;
      end
      bus.start       = sa;
      bus.stop        = st;
      bus.sw_rst      = sw;
      bus.sample_tick = tk;
      bus.len_we      = lw;
      bus.len_data    = lw ? LEN_W'(9) : LEN_W'($urandom);
      if (k >= 1) begin
        e.dp_n   += int'(k >= dp_a && k <= dp_b);
        e.fl_n   += int'(k >= fl_a && k <= fl_b);
        e.done_n += int'(k == done_at);
        e.acc_n  += int'(in_run && tk);
      end
      if (lw) m_run_len = 9;
      fin = 1'b0;
      if (sw) begin
        swr = 1'b1; dp_a = k + 1; dp_b = k + R; run_a = BIG; run_b = -1;
        fl_a = BIG; fl_b = -1; done_at = -1; idle_at = k + R + 1; cnt = 0; ab = 0;
      end else if (st && !swr && k >= 1 && k < run_a) begin
        idle_at = k + 1; dp_b = k; run_a = BIG; run_b = -1; ab = 1;
      end else if (in_run && (tk || st)) begin
        if (tk) cnt++;
        if (tk && act_len != 0 && cnt == act_len) fin = 1'b1;
        else if (st) begin
          ab = 1; fin = 1'b1;
        end
      end
      if (fin) begin
        run_b = k; fl_a = k + 1; fl_b = k + F; done_at = k + F + 1; idle_at = k + F + 2;
      end
      @(posedge clk); #1;
    end
    vectors++;
    miscompares++;
    $display("[TB] FAIL episode_timeout: actual=no end required=end within 4000 cycles");
  endtask

  initial begin
    int len, sk, pct;
    zeroInputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_tick_cnt", bus.tick_cnt, 0);
    checkOutput("reset_aborted", bus.aborted, 0);
    checkOutput("reset_dp_rst", bus.dp_rst, 0);
    rst = 1'b0;
    idleGap(2);

    $display("[TB] normal run, length 5, tick every third cycle");
    writeLen(5);
    applyStimulus(-1, -1, 0, -1, -1, M_NONE);
    idleGap(3);
    $display("[TB] free run stopped with the 7th tick");
    writeLen(0);
    applyStimulus(40, -1, 7, -1, -1, M_NONE);
    idleGap(2);
    $display("[TB] stop coinciding with the completing tick");
    writeLen(5);
    applyStimulus(50, -1, 5, -1, -1, M_NONE);
    idleGap(3);
    $display("[TB] start+stop+sw_rst together in RUN");
    applyStimulus(50, -1, 0, -1, -1, M_TRIPLE);
    idleGap(2);
    $display("[TB] length rewritten mid-run, then a run using the new length");
    writeLen(3);
    applyStimulus(60, -1, 0, -1, -1, M_LENWE);
    idleGap(2);
    applyStimulus(60, -1, 0, -1, -1, M_START_LATE);
    idleGap(3);
    $display("[TB] stop during CLEAR, sw_rst during FLUSH");
    applyStimulus(50, 2, 0, -1, -1, M_NONE);
    idleGap(2);
    applyStimulus(70, -1, 0, -1, -1, M_SW_FLUSH);
    idleGap(2);
    $display("[TB] hardware reset mid-run, then a free run");
    applyStimulus(60, -1, 0, -1, R + 6, M_NONE);
    idleGap(3);
    applyStimulus(50, 30, 0, -1, -1, M_NONE);
    idleGap(2);
    applyStimulus(50, -1, 0, 0, -1, M_NONE);
    idleGap(2);

    $display("[TB] randomised runs");
    for (int i = 0; i < 10; i++) begin
      len = int'($urandom_range(6));
      pct = int'($urandom_range(90, 20));
      if (len == 0) sk = int'($urandom_range(40, 6));
      else sk = ($urandom_range(3) == 0) ? int'($urandom_range(30, 1)) : -1;
      writeLen(len);
      applyStimulus(pct, sk, 0, -1, -1, M_NONE);
      idleGap(int'($urandom_range(4, 1)));
    end

    idleGap(5);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    checkOutput("episode_closed", in_ep, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
